// File: rtl/uart_fifo_core.sv
// uart_fifo_core
//   UART transmitter and receiver sharing one 16x-oversample tick generator,
//   with a small RX FIFO that carries {ferr, perr, data} per received frame.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   divisor           : clocks per oversample tick (0 behaves as 1)
//   data_bits         : 00=5, 01=6, 10=7, 11=8 data bits
//   parity_en/odd     : parity enable, odd parity select
//   stop2             : two stop bits on TX (RX checks only the first)
//   tx_data/valid/ready, tx_busy, txd : TX byte handshake and serial output
//   rxd               : asynchronous serial input
//   rx_data/perr/ferr/valid/ready     : FIFO head and pop handshake
//   rx_count          : FIFO occupancy
//   overrun, overrun_clr              : sticky overflow flag and its clear
module uart_fifo_core #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              divisor,
    input  logic [1:0]                    data_bits,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop2,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic                          txd,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overrun,
    input  logic                          overrun_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    function automatic logic [7:0] data_mask(input logic [1:0] db);
        case (db)
            2'b00:   data_mask = 8'h1F;
            2'b01:   data_mask = 8'h3F;
            2'b10:   data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
    endfunction

    // ---------------- tick generator ----------------
    logic [DIV_W-1:0] tick_cnt;
    logic [DIV_W-1:0] div_eff;
    logic             tick;

    always_comb begin
        div_eff = (divisor == '0) ? DIV_W'(1) : divisor;
        // >= keeps the counter bounded if divisor is lowered mid-count
        tick    = (tick_cnt >= div_eff - DIV_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + DIV_W'(1);
    end

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    tx_state_t  tx_state, tx_state_n;
    logic [3:0] tx_tcnt, tx_tcnt_n;
    logic [2:0] tx_bit, tx_bit_n;
    logic [2:0] tx_last, tx_last_n;
    logic [7:0] tx_shift, tx_shift_n;
    logic       tx_pen, tx_pen_n;
    logic       tx_pbit, tx_pbit_n;
    logic       tx_two, tx_two_n;
    logic       tx_stop_cnt, tx_stop_cnt_n;
    logic       tx_bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            tx_tcnt     <= '0;
            tx_bit      <= '0;
            tx_last     <= '0;
            tx_shift    <= '0;
            tx_pen      <= 1'b0;
            tx_pbit     <= 1'b0;
            tx_two      <= 1'b0;
            tx_stop_cnt <= 1'b0;
        end else begin
            tx_state    <= tx_state_n;
            tx_tcnt     <= tx_tcnt_n;
            tx_bit      <= tx_bit_n;
            tx_last     <= tx_last_n;
            tx_shift    <= tx_shift_n;
            tx_pen      <= tx_pen_n;
            tx_pbit     <= tx_pbit_n;
            tx_two      <= tx_two_n;
            tx_stop_cnt <= tx_stop_cnt_n;
        end
    end

    always_comb begin
        tx_state_n    = tx_state;
        tx_tcnt_n     = tx_tcnt;
        tx_bit_n      = tx_bit;
        tx_last_n     = tx_last;
        tx_shift_n    = tx_shift;
        tx_pen_n      = tx_pen;
        tx_pbit_n     = tx_pbit;
        tx_two_n      = tx_two;
        tx_stop_cnt_n = tx_stop_cnt;
        tx_bit_end    = tick && (tx_tcnt == 4'd15);

        if (tick && (tx_state != TX_IDLE))
            tx_tcnt_n = tx_tcnt + 4'd1;

        case (tx_state)
            TX_IDLE: begin
                if (tx_valid) begin
                    // Frame configuration is captured here and held to the end
                    tx_state_n = TX_START;
                    tx_tcnt_n  = '0;
                    tx_shift_n = tx_data;
                    tx_last_n  = 3'd4 + {1'b0, data_bits};
                    tx_pen_n   = parity_en;
                    tx_pbit_n  = (^(tx_data & data_mask(data_bits))) ^ parity_odd;
                    tx_two_n   = stop2;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_n = TX_DATA;
                    tx_bit_n   = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_n = tx_shift >> 1;
                    if (tx_bit == tx_last) begin
                        tx_state_n    = tx_pen ? TX_PARITY : TX_STOP;
                        tx_stop_cnt_n = 1'b0;
                    end else begin
                        tx_bit_n = tx_bit + 3'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_n    = TX_STOP;
                    tx_stop_cnt_n = 1'b0;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_two && !tx_stop_cnt) tx_stop_cnt_n = 1'b1;
                    else                        tx_state_n    = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (tx_state == TX_IDLE);
        tx_busy  = ~tx_ready;
        case (tx_state)
            TX_START:  txd = 1'b0;
            TX_DATA:   txd = tx_shift[0];
            TX_PARITY: txd = tx_pbit;
            default:   txd = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic       rx_sync1, rx_sync2, rx_prev;
    rx_state_t  rx_state, rx_state_n;
    logic [3:0] rx_tcnt, rx_tcnt_n;
    logic [2:0] rx_bit, rx_bit_n;
    logic [2:0] rx_last, rx_last_n;
    logic [7:0] rx_shift, rx_shift_n;
    logic       rx_pen, rx_pen_n;
    logic       rx_podd, rx_podd_n;
    logic       rx_pbit, rx_pbit_n;
    logic       rx_sample;
    logic       push;
    logic [9:0] push_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_last  <= '0;
            rx_shift <= '0;
            rx_pen   <= 1'b0;
            rx_podd  <= 1'b0;
            rx_pbit  <= 1'b0;
        end else begin
            rx_sync1 <= rxd;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
            rx_state <= rx_state_n;
            rx_tcnt  <= rx_tcnt_n;
            rx_bit   <= rx_bit_n;
            rx_last  <= rx_last_n;
            rx_shift <= rx_shift_n;
            rx_pen   <= rx_pen_n;
            rx_podd  <= rx_podd_n;
            rx_pbit  <= rx_pbit_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_tcnt_n  = rx_tcnt;
        rx_bit_n   = rx_bit;
        rx_last_n  = rx_last;
        rx_shift_n = rx_shift;
        rx_pen_n   = rx_pen;
        rx_podd_n  = rx_podd;
        rx_pbit_n  = rx_pbit;
        push       = 1'b0;
        // rx_shift holds only received bits (upper bits zeroed), so a full
        // reduction gives the parity of the configured data width
        push_word  = {~rx_sync2,
                      rx_pen & ((^rx_shift ^ rx_podd) != rx_pbit),
                      rx_shift};
        // Counter restarts at mid-start, so a wrap to 15 lands on bit centres
        rx_sample  = tick && (rx_tcnt == 4'd15);

        if (tick && (rx_state != RX_IDLE))
            rx_tcnt_n = rx_tcnt + 4'd1;

        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync2) begin
                    rx_state_n = RX_START;
                    rx_tcnt_n  = '0;
                    rx_shift_n = '0;
                    rx_last_n  = 3'd4 + {1'b0, data_bits};
                    rx_pen_n   = parity_en;
                    rx_podd_n  = parity_odd;
                end
            end
            RX_START: begin
                if (tick && (rx_tcnt == 4'd7)) begin
                    if (rx_sync2) begin
                        rx_state_n = RX_IDLE;     // false start
                    end else begin
                        rx_state_n = RX_DATA;
                        rx_tcnt_n  = '0;
                        rx_bit_n   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_n[rx_bit] = rx_sync2;
                    if (rx_bit == rx_last) rx_state_n = rx_pen ? RX_PARITY : RX_STOP;
                    else                   rx_bit_n   = rx_bit + 3'd1;
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_pbit_n  = rx_sync2;
                    rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    push       = 1'b1;
                    rx_state_n = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop, full, push_ok, ovr_evt;

    always_comb begin
        rx_valid = (rx_count != '0);
        pop      = rx_valid & rx_ready;
        full     = (rx_count == CW'(FIFO_DEPTH));
        push_ok  = push & (~full | pop);
        ovr_evt  = push & full & ~pop;
        // Gate the head with rx_valid so outputs read zero when empty/reset
        {rx_ferr, rx_perr, rx_data} = rx_valid ? mem[rd_ptr] : 10'd0;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
            overrun  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
            if (ovr_evt)          overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_core.sv
`timescale 1ns/1ps
module tb_uart_fifo_core;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] divisor;
    logic [1:0]  data_bits;
    logic        parity_en, parity_odd, stop2;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_busy, txd;
    logic        rxd, rxd_drv, loop;
    logic [7:0]  rx_data;
    logic        rx_perr, rx_ferr, rx_valid, rx_ready;
    logic [3:0]  rx_count;
    logic        overrun, overrun_clr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: FIFO of {ferr, perr, data} plus sticky overrun flag
    logic [9:0] mq[$];
    logic       m_ovr = 1'b0;

    assign rxd = loop ? txd : rxd_drv;

    uart_fifo_core #(.DIV_W(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .divisor(divisor), .data_bits(data_bits),
        .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_busy(tx_busy), .txd(txd), .rxd(rxd),
        .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_count(rx_count),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model helpers ----------------
    function automatic int div_eff();
        return (divisor == 16'd0) ? 1 : int'(divisor);
    endfunction

    function automatic int nbits_of(input logic [1:0] db);
        return 5 + int'(db);
    endfunction

    function automatic logic [7:0] mask_of(input int n);
        return 8'((1 << n) - 1);
    endfunction

    function automatic logic par_of(input logic [7:0] d, input int n, input logic odd);
        return ((($countones(d & mask_of(n))) % 2) == 1) ^ odd;
    endfunction

    function automatic int frame_len(input int n, input logic pen, input logic s2);
        return 2 + n + int'(pen) + int'(s2);
    endfunction

    // Line levels of one frame, bit 0 = start; unused positions idle high
    function automatic logic [11:0] exp_frame(input logic [7:0] d, input int n,
                                              input logic pen, input logic odd);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < n; i++) f[1+i] = d[i];
        if (pen) f[1+n] = par_of(d, n, odd);
        return f;
    endfunction

    function automatic void model_push(input logic [9:0] e);
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovr = 1'b1;
    endfunction

    function automatic logic [10:0] model_pop();
        if (mq.size() == 0) return 11'h0;
        return {1'b1, mq.pop_front()};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_send_capture(input logic [7:0] d, output logic [11:0] bits,
                                   output int nb, output int el);
        int bt, acc, w;
        bt   = 16 * div_eff();
        nb   = frame_len(nbits_of(data_bits), parity_en, stop2);
        bits = '1;
        el   = -1;
        w = 0;
        while (tx_ready !== 1'b1 && w < 20000) begin hold(1); w++; end
        if (tx_ready !== 1'b1) return;
        tx_data  = d;
        tx_valid = 1'b1;
        hold(1);
        tx_valid = 1'b0;
        acc = cyc;
        for (int k = 0; k < nb; k++) begin
            while (cyc < acc + bt/2 + k*bt) hold(1);
            bits[k] = txd;
        end
        w = 0;
        while (tx_ready !== 1'b1 && w < nb*bt + 100) begin hold(1); w++; end
        if (tx_ready === 1'b1) el = cyc - acc;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic pflip, input logic stopv);
        int bt, n;
        bt = 16 * div_eff();
        n  = nbits_of(data_bits);
        rxd_drv = 1'b0; hold(bt);
        for (int i = 0; i < n; i++) begin rxd_drv = d[i]; hold(bt); end
        if (parity_en) begin rxd_drv = par_of(d, n, parity_odd) ^ pflip; hold(bt); end
        rxd_drv = stopv; hold(bt);
        rxd_drv = 1'b1;  hold(bt);
    endtask

    task automatic pop_entry(output logic [10:0] got);
        got = {rx_valid, rx_ferr, rx_perr, rx_data};
        rx_ready = 1'b1;
        hold(1);
        rx_ready = 1'b0;
    endtask

    task automatic set_cfg(input int dv, input logic [1:0] db, input logic pe,
                           input logic po, input logic s2);
        divisor = 16'(dv); data_bits = db; parity_en = pe; parity_odd = po; stop2 = s2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        total++;
        if ({txd, tx_ready, tx_busy} !== 3'b110) begin
            bad++; $display("FAIL reset_tx: got txd/rdy/busy=%b want 110", {txd, tx_ready, tx_busy});
        end
        total++;
        if ({rx_valid, rx_count, overrun} !== 6'b0) begin
            bad++; $display("FAIL reset_rxctl: got valid=%b count=%0d ovr=%b want 0/0/0", rx_valid, rx_count, overrun);
        end
        hold(3);
        total++;
        if ({rx_ferr, rx_perr, rx_data, txd, tx_ready} !== {10'h0, 2'b11}) begin
            bad++; $display("FAIL reset_hold: got f=%b p=%b d=%h txd=%b rdy=%b want 0 0 00 1 1",
                            rx_ferr, rx_perr, rx_data, txd, tx_ready);
        end
        rst = 1'b0;
        hold(2);
    endtask

    task automatic test_tx_8n1();
        logic [11:0] bits, exp;
        int nb, el;
        loop = 1'b0; rxd_drv = 1'b1;
        set_cfg(4, 2'b11, 1'b0, 1'b0, 1'b0);
        tx_send_capture(8'hA5, bits, nb, el);
        exp = exp_frame(8'hA5, 8, 1'b0, 1'b0);
        for (int k = 0; k < nb; k++) begin
            total++;
            if (bits[k] !== exp[k]) begin
                bad++; $display("FAIL tx8n1_bit%0d: got %b want %b", k, bits[k], exp[k]);
            end
        end
        total++;
        if (el < 636 || el > 644) begin
            bad++; $display("FAIL tx8n1_ready_time: got %0d clocks want 640+-4", el);
        end
    endtask

    task automatic test_loopback_8e1();
        logic [11:0] bits;
        logic [10:0] got, exp;
        int nb, el;
        loop = 1'b1;
        set_cfg(2, 2'b11, 1'b1, 1'b0, 1'b0);
        tx_send_capture(8'h5A, bits, nb, el);
        model_push({1'b0, 1'b0, 8'h5A});
        hold(2);
        total++;
        if (bits !== exp_frame(8'h5A, 8, 1'b1, 1'b0)) begin
            bad++; $display("FAIL lb8e1_txd: got %b want %b", bits, exp_frame(8'h5A, 8, 1'b1, 1'b0));
        end
        total++;
        if (rx_count !== 4'(mq.size())) begin
            bad++; $display("FAIL lb8e1_count: got %0d want %0d", rx_count, mq.size());
        end
        exp = model_pop();
        pop_entry(got);
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL lb8e1_data: got %h want %h", got, exp);
        end
    endtask

    task automatic test_loopback_random();
        logic [11:0] bits;
        logic [10:0] got, exp;
        logic [7:0]  d;
        int nb, el, n;
        loop = 1'b1;
        for (int it = 0; it < 8; it++) begin
            set_cfg((it == 0) ? 0 : int'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 1'($urandom));
            d = 8'($urandom);
            n = nbits_of(data_bits);
            tx_send_capture(d, bits, nb, el);
            model_push({1'b0, 1'b0, d & mask_of(n)});
            hold(2);
            total++;
            if (bits !== exp_frame(d, n, parity_en, parity_odd)) begin
                bad++; $display("FAIL rand%0d_txd: got %b want %b", it, bits, exp_frame(d, n, parity_en, parity_odd));
            end
            total++;
            if (el < nb*16*div_eff() - div_eff() || el > nb*16*div_eff() + div_eff()) begin
                bad++; $display("FAIL rand%0d_len: got %0d want %0d", it, el, nb*16*div_eff());
            end
            exp = model_pop();
            pop_entry(got);
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL rand%0d_rx: got %h want %h", it, got, exp);
            end
        end
    endtask

    task automatic test_5bit();
        logic [11:0] bits;
        logic [10:0] got;
        int nb, el;
        loop = 1'b1;
        set_cfg(1, 2'b00, 1'b0, 1'b0, 1'b0);
        tx_send_capture(8'hFF, bits, nb, el);
        model_push({2'b00, 8'hFF & mask_of(5)});
        hold(2);
        total++;
        if (bits[6:0] !== 7'b1111110) begin
            bad++; $display("FAIL 5bit_txd: got %b want 1111110", bits[6:0]);
        end
        void'(model_pop());
        pop_entry(got);
        total++;
        if (got !== {1'b1, 2'b00, 8'h1F}) begin
            bad++; $display("FAIL 5bit_rx: got %h want %h", got, {1'b1, 2'b00, 8'h1F});
        end
    endtask

    task automatic test_rx_errors();
        logic [10:0] got, exp;
        loop = 1'b0; rxd_drv = 1'b1;
        set_cfg(2, 2'b11, 1'b1, 1'b0, 1'b0);
        rx_frame(8'h00, 1'b1, 1'b1); model_push({1'b0, 1'b1, 8'h00});
        rx_frame(8'h3C, 1'b0, 1'b0); model_push({1'b1, 1'b0, 8'h3C});
        parity_odd = 1'b1;
        rx_frame(8'h07, 1'b0, 1'b1); model_push({1'b0, 1'b0, 8'h07});
        parity_en = 1'b0;
        rx_frame(8'hC3, 1'b1, 1'b1); model_push({1'b0, 1'b0, 8'hC3});
        total++;
        if (rx_count !== 4'(mq.size())) begin
            bad++; $display("FAIL rxerr_count: got %0d want %0d", rx_count, mq.size());
        end
        for (int i = 0; i < 4; i++) begin
            exp = model_pop();
            pop_entry(got);
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL rxerr_entry%0d: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_overrun();
        logic [10:0] got, exp;
        loop = 1'b0; rxd_drv = 1'b1;
        set_cfg(2, 2'b11, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            rx_frame(8'(i), 1'b0, 1'b1);
            model_push({2'b00, 8'(i)});
        end
        total++;
        if (rx_count !== 4'(mq.size())) begin
            bad++; $display("FAIL ovr_count: got %0d want %0d", rx_count, mq.size());
        end
        total++;
        if (overrun !== m_ovr) begin
            bad++; $display("FAIL ovr_flag: got %b want %b", overrun, m_ovr);
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp = model_pop();
            pop_entry(got);
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL ovr_pop%0d: got %h want %h", i, got, exp);
            end
        end
        total++;
        if (overrun !== 1'b1) begin
            bad++; $display("FAIL ovr_sticky: got %b want 1", overrun);
        end
        overrun_clr = 1'b1; hold(1); overrun_clr = 1'b0; m_ovr = 1'b0;
        total++;
        if (overrun !== m_ovr) begin
            bad++; $display("FAIL ovr_clear: got %b want %b", overrun, m_ovr);
        end
        rx_ready = 1'b1; hold(3); rx_ready = 1'b0;
        total++;
        if ({rx_valid, rx_count} !== 5'b0) begin
            bad++; $display("FAIL pop_empty: got valid=%b count=%0d want 0/0", rx_valid, rx_count);
        end
    endtask

    task automatic test_glitch();
        logic [10:0] got, exp;
        loop = 1'b0; rxd_drv = 1'b1;
        set_cfg(2, 2'b11, 1'b0, 1'b0, 1'b0);
        for (int g = 1; g <= 3; g++) begin
            rxd_drv = 1'b0; hold(2 * g * div_eff());
            rxd_drv = 1'b1; hold(200);
            total++;
            if (rx_count !== 4'(mq.size())) begin
                bad++; $display("FAIL glitch%0d_count: got %0d want %0d", g, rx_count, mq.size());
            end
        end
        rx_frame(8'h96, 1'b0, 1'b1);
        model_push({2'b00, 8'h96});
        exp = model_pop();
        pop_entry(got);
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL glitch_after: got %h want %h", got, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] bits, exp;
        int nb, el, acc, w;
        loop = 1'b1;
        set_cfg(4, 2'b11, 1'b0, 1'b0, 1'b0);
        tx_send_capture(8'h3C, bits, nb, el);
        model_push({2'b00, 8'h3C});
        hold(2);
        total++;
        if (rx_count !== 4'(mq.size())) begin
            bad++; $display("FAIL rstmid_pre_count: got %0d want %0d", rx_count, mq.size());
        end
        w = 0;
        while (tx_ready !== 1'b1 && w < 2000) begin hold(1); w++; end
        tx_data = 8'hA5; tx_valid = 1'b1; hold(1); tx_valid = 1'b0;
        acc = cyc;
        exp = exp_frame(8'hA5, 8, 1'b0, 1'b0);
        while (cyc < acc + 32 + 4*64) hold(1);
        total++;
        if (txd !== exp[4]) begin
            bad++; $display("FAIL rstmid_bit3: got %b want %b", txd, exp[4]);
        end
        #2 rst = 1'b1;
        #1;
        mq.delete(); m_ovr = 1'b0;
        total++;
        if ({txd, tx_ready, tx_busy} !== 3'b110) begin
            bad++; $display("FAIL rstmid_tx: got txd/rdy/busy=%b want 110", {txd, tx_ready, tx_busy});
        end
        total++;
        if ({rx_valid, rx_count} !== 5'b0) begin
            bad++; $display("FAIL rstmid_rx: got valid=%b count=%0d want 0/0", rx_valid, rx_count);
        end
        hold(2);
        rst = 1'b0;
        hold(1000);
        total++;
        if ({rx_count, txd, tx_ready} !== {4'(mq.size()), 2'b11}) begin
            bad++; $display("FAIL rstmid_after: got count=%0d txd=%b rdy=%b want %0d 1 1",
                            rx_count, txd, tx_ready, mq.size());
        end
    endtask

    initial begin
        rst = 1'b0; loop = 1'b0; rxd_drv = 1'b1;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; overrun_clr = 1'b0;
        set_cfg(4, 2'b11, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_tx_8n1();
        test_loopback_8e1();
        test_loopback_random();
        test_5bit();
        test_rx_errors();
        test_overrun();
        test_glitch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
